// File: rtl/button_conditioner.sv
// Push-button conditioner: 2-flop synchronizer, debounce FSM and auto-repeat strobe.
// Both outputs come straight from flops, so neither has a combinational path from raw_button.
module button_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned HOLD_CYCLES     = 25000000,
  parameter int unsigned REPEAT_CYCLES   = 5000000
) (
  input  logic clk,
  input  logic reset,
  input  logic raw_button,
  input  logic repeat_en,
  output logic debounced_level,
  output logic repeat_tick
);

  localparam logic [25:0] DbLast   = 26'(DEBOUNCE_CYCLES - 1);
  localparam logic [25:0] HoldLast = 26'(HOLD_CYCLES - 1);
  localparam logic [25:0] RptLast  = 26'(REPEAT_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StPressWait, StPressed, StReleaseWait} state_e;

  state_e      state_q;
  logic        sync_meta_q;
  logic        sync_in;
  logic [25:0] dcnt;
  logic [25:0] hcnt;
  logic        repeating_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_meta_q <= 1'b0;
      sync_in     <= 1'b0;
    end else begin
      sync_meta_q <= raw_button;
      sync_in     <= sync_meta_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q         <= StIdle;
      dcnt            <= '0;
      hcnt            <= '0;
      repeating_q     <= 1'b0;
      debounced_level <= 1'b0;
      repeat_tick     <= 1'b0;
    end else begin
      repeat_tick <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (sync_in) begin
            state_q <= StPressWait;
            dcnt    <= '0;
          end
        end
        StPressWait: begin
          if (!sync_in) begin
            state_q <= StIdle;
          end else if (dcnt == DbLast) begin
            state_q         <= StPressed;
            hcnt            <= '0;
            repeating_q     <= 1'b0;
            debounced_level <= 1'b1;
          end else begin
            dcnt <= dcnt + 26'd1;
          end
        end
        StPressed: begin
          // A falling sample wins over a coincident tick; hcnt freezes until the press resumes.
          if (!sync_in) begin
            state_q <= StReleaseWait;
            dcnt    <= '0;
          end else if (hcnt == (repeating_q ? RptLast : HoldLast)) begin
            hcnt        <= '0;
            repeating_q <= 1'b1;
            repeat_tick <= repeat_en;
          end else begin
            hcnt <= hcnt + 26'd1;
          end
        end
        StReleaseWait: begin
          if (sync_in) begin
            state_q <= StPressed;
          end else if (dcnt == DbLast) begin
            state_q         <= StIdle;
            debounced_level <= 1'b0;
          end else begin
            dcnt <= dcnt + 26'd1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
